// File: rtl/vram_sprite_loader_pkg.sv
// Shared VGA sprite definitions: the loader and the drawer must agree on
// the frame geometry and address width, so both import this package.
package vga_pkg;

  localparam int DEF_SPRITE_WIDTH  = 200;
  localparam int DEF_SPRITE_HEIGHT = 230;
  localparam int DEF_ADDR_W        = 18;
  localparam int PIX_W             = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } loader_state_t;

endpackage

// File: rtl/vram_sprite_loader_if.sv
// Pixel stream in (valid/ready) plus the VRAM write port, bundled so the
// loader and its neighbours connect through a single port.
interface vram_sprite_loader_if #(
  parameter int ADDR_W = vga_pkg::DEF_ADDR_W
);
  import vga_pkg::*;

  logic              s_valid;
  logic              s_sof;
  logic [PIX_W-1:0]  s_data;
  logic              s_ready;
  logic              wr_stall;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_waddr;
  logic [PIX_W-1:0]  vram_wdata;

  // Pixel source and VRAM port side.
  modport master (
    output s_valid, s_sof, s_data, wr_stall,
    input  s_ready, vram_we, vram_waddr, vram_wdata
  );

  // Loader side.
  modport slave (
    input  s_valid, s_sof, s_data, wr_stall,
    output s_ready, vram_we, vram_waddr, vram_wdata
  );

endinterface

// File: rtl/vram_sprite_loader_addr_gen.sv
// Row-major write address generator. row_base accumulates SPRITE_WIDTH on
// each row wrap, so the address is a plain sum with no multiplier.
module sprite_addr_gen
  import vga_pkg::*;
#(
  parameter int SPRITE_WIDTH  = DEF_SPRITE_WIDTH,
  parameter int SPRITE_HEIGHT = DEF_SPRITE_HEIGHT,
  parameter int VRAM_BASE     = 0,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] COL_MAX    = ADDR_W'(SPRITE_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX    = ADDR_W'(SPRITE_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] WIDTH_STEP = ADDR_W'(SPRITE_WIDTH);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(VRAM_BASE);

  // The restart beat itself lands on (0,0); these give the position after it.
  // A one-pixel-wide sprite wraps straight to the next row, and a 1x1 sprite
  // is already complete, so the counters go back to zero.
  localparam bit               ONE_COL      = (SPRITE_WIDTH == 1);
  localparam bit               MULTI_ROW    = (SPRITE_HEIGHT > 1);
  localparam logic [ADDR_W-1:0] RESTART_COL = ONE_COL ? '0 : ADDR_W'(1);
  localparam logic [ADDR_W-1:0] RESTART_ROW = (ONE_COL && MULTI_ROW) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] RESTART_RB  = (ONE_COL && MULTI_ROW) ? WIDTH_STEP : '0;

  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] row_base;
  logic              col_wrap;

  assign col_wrap = (col == COL_MAX);
  assign last     = col_wrap && (row == ROW_MAX);
  assign addr     = BASE + row_base + col;

  // Position counters: restart wins over advance; the last pixel rewinds to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (restart) begin
      col      <= RESTART_COL;
      row      <= RESTART_ROW;
      row_base <= RESTART_RB;
    end else if (advance) begin
      if (last) begin
        col      <= '0;
        row      <= '0;
        row_base <= '0;
      end else if (col_wrap) begin
        col      <= '0;
        row      <= row + ADDR_W'(1);
        row_base <= row_base + WIDTH_STEP;
      end else begin
        col <= col + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/vram_sprite_loader.sv
// Sprite frame loader: takes a byte-wide pixel stream and writes one frame
// into VRAM in the same row-major order the drawer reads it back.
module vram_sprite_loader
  import vga_pkg::*;
#(
  parameter int SPRITE_WIDTH  = DEF_SPRITE_WIDTH,
  parameter int SPRITE_HEIGHT = DEF_SPRITE_HEIGHT,
  parameter int VRAM_BASE     = 0,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  vram_sprite_loader_if.slave  bus,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(VRAM_BASE);
  localparam bit                SOF_IS_LAST = (SPRITE_WIDTH == 1) && (SPRITE_HEIGHT == 1);

  loader_state_t     state;
  loader_state_t     state_next;
  logic              ready;
  logic              accept;
  logic              restart;
  logic              advance;
  logic              wr_en;
  logic              err_next;
  logic              done_next;
  logic              last;
  logic [ADDR_W-1:0] cur_addr;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [PIX_W-1:0]  wdata_q;

  sprite_addr_gen #(
    .SPRITE_WIDTH  (SPRITE_WIDTH),
    .SPRITE_HEIGHT (SPRITE_HEIGHT),
    .VRAM_BASE     (VRAM_BASE),
    .ADDR_W        (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .restart (restart),
    .addr    (cur_addr),
    .last    (last)
  );

  assign ready          = (state == IDLE) || ((state == RECV) && !bus.wr_stall);
  assign accept         = bus.s_valid && ready;
  assign bus.s_ready    = ready;
  assign bus.vram_we    = we_q;
  assign bus.vram_waddr = waddr_q;
  assign bus.vram_wdata = wdata_q;
  assign busy           = (state == RECV);
  assign done_next      = wr_en && (state_next == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-beat control: what to write and how the counters move.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    advance    = 1'b0;
    wr_en      = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && bus.s_sof) begin
          restart    = 1'b1;
          wr_en      = 1'b1;
          state_next = SOF_IS_LAST ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          wr_en = 1'b1;
          if (bus.s_sof) begin
            restart    = 1'b1;
            err_next   = 1'b1;
            state_next = SOF_IS_LAST ? DONE : RECV;
          end else begin
            advance = 1'b1;
            if (last) begin
              state_next = DONE;
            end
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered write port and status pulses, one cycle behind the accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      we_q       <= wr_en;
      frame_done <= done_next;
      frame_err  <= err_next;
      if (wr_en) begin
        waddr_q <= restart ? BASE : cur_addr;
        wdata_q <= bus.s_data;
      end
    end
  end

endmodule

// File: tb/tb_vram_sprite_loader.sv
// Directed bench: a small 4x3 sprite at base 100 for the cycle-level checks
// and a default-geometry instance for one full 46000-pixel frame.
`timescale 1ns/1ps
module tb_vram_sprite_loader;
  import vga_pkg::*;

  typedef struct {
    logic       valid;
    logic       sof;
    logic [7:0] data;
    logic       stall;
    logic       exp_ready;
    logic       exp_we;
    logic [17:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_done;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  localparam int NVEC = 18;
  localparam int NO_STALL = 100000;

  logic clk;
  logic rst;
  logic a_done, a_err, a_busy;
  logic b_done, b_err, b_busy;

  int n_applied;
  int n_miscompares;

  vec_t vecs [NVEC];

  logic [17:0] wa_q [$];
  logic [7:0]  wd_q [$];
  logic        wdone_q [$];
  logic        werr_q [$];
  int          a_done_cnt;
  int          a_err_cnt;

  int          b_wr_cnt;
  int          b_done_cnt;
  logic [17:0] b_first_addr;
  logic [17:0] b_last_addr;
  logic [17:0] b_max_addr;

  vram_sprite_loader_if #(.ADDR_W(18)) a_if ();
  vram_sprite_loader_if #(.ADDR_W(18)) b_if ();

  vram_sprite_loader #(
    .SPRITE_WIDTH  (4),
    .SPRITE_HEIGHT (3),
    .VRAM_BASE     (100),
    .ADDR_W        (18)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (a_if.slave),
    .frame_done (a_done),
    .frame_err  (a_err),
    .busy       (a_busy)
  );

  vram_sprite_loader dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (b_if.slave),
    .frame_done (b_done),
    .frame_err  (b_err),
    .busy       (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write and status pulse of the small instance.
  initial begin
    a_done_cnt = 0;
    a_err_cnt  = 0;
    forever begin
      @(negedge clk);
      if (a_if.vram_we === 1'b1) begin
        wa_q.push_back(a_if.vram_waddr);
        wd_q.push_back(a_if.vram_wdata);
        wdone_q.push_back(a_done);
        werr_q.push_back(a_err);
      end
      if (a_done === 1'b1) a_done_cnt++;
      if (a_err === 1'b1) a_err_cnt++;
    end
  end

  // Summarise the write stream of the full-size instance.
  initial begin
    b_wr_cnt     = 0;
    b_done_cnt   = 0;
    b_first_addr = '0;
    b_last_addr  = '0;
    b_max_addr   = '0;
    forever begin
      @(negedge clk);
      if (b_if.vram_we === 1'b1) begin
        if (b_wr_cnt == 0) b_first_addr = b_if.vram_waddr;
        b_last_addr = b_if.vram_waddr;
        if (b_if.vram_waddr > b_max_addr) b_max_addr = b_if.vram_waddr;
        b_wr_cnt++;
      end
      if (b_done === 1'b1) b_done_cnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Push n beats into the small instance, wr_stall high for frame cycles lo..hi.
  task automatic applyStimulus(input int n, input int d0, input bit sof0, input int lo, input int hi);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < n + 50) begin
      @(negedge clk);
      a_if.wr_stall = (cyc >= lo) && (cyc <= hi);
      a_if.s_valid  = 1'b1;
      a_if.s_sof    = sof0 && (sent == 0);
      a_if.s_data   = 8'(d0 + sent);
      #1;
      if (a_if.wr_stall) checkOutput("stall_ready", 32'(a_if.s_ready), 32'd0);
      if (a_if.s_ready === 1'b1) sent++;
      cyc++;
    end
    checkOutput("beats_accepted", 32'(sent), 32'(n));
    @(negedge clk);
    a_if.s_valid  = 1'b0;
    a_if.s_sof    = 1'b0;
    a_if.wr_stall = 1'b0;
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d, input logic st,
                              input logic rdy, input logic we, input logic [17:0] ad,
                              input logic [7:0] dd, input logic dn, input logic er, input logic bz);
    vec_t r;
    r.valid = v; r.sof = s; r.data = d; r.stall = st;
    r.exp_ready = rdy; r.exp_we = we; r.exp_addr = ad; r.exp_data = dd;
    r.exp_done = dn; r.exp_err = er; r.exp_busy = bz;
    return r;
  endfunction

  initial begin
    int s0;
    int dn0;
    int er0;
    int sent;
    int cyc;

    n_applied     = 0;
    n_miscompares = 0;

    // Three dropped non-sof beats in IDLE, one quiet cycle, then a full
    // 4x3 frame at base 100 and two tail cycles (DONE, back to IDLE).
    for (int i = 0; i < 3; i++)
      vecs[i] = mk(1'b1, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 18'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 18'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++)
      vecs[4+k] = mk(1'b1, (k == 0), 8'(k), 1'b0, 1'b1, (k > 0), 18'(100 + k - 1),
                     8'(k - 1), 1'b0, 1'b0, (k > 0));
    vecs[16] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 18'd111, 8'd11, 1'b1, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 18'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    a_if.s_valid = 1'b0; a_if.s_sof = 1'b0; a_if.s_data = 8'd0; a_if.wr_stall = 1'b0;
    b_if.s_valid = 1'b0; b_if.s_sof = 1'b0; b_if.s_data = 8'd0; b_if.wr_stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_we",    32'(a_if.vram_we),    32'd0);
    checkOutput("rst_waddr", 32'(a_if.vram_waddr), 32'd0);
    checkOutput("rst_wdata", 32'(a_if.vram_wdata), 32'd0);
    checkOutput("rst_done",  32'(a_done),          32'd0);
    checkOutput("rst_err",   32'(a_err),           32'd0);
    checkOutput("rst_busy",  32'(a_busy),          32'd0);
    checkOutput("rst_ready", 32'(a_if.s_ready),    32'd1);
    rst = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      a_if.s_valid  = vecs[i].valid;
      a_if.s_sof    = vecs[i].sof;
      a_if.s_data   = vecs[i].data;
      a_if.wr_stall = vecs[i].stall;
      #1;
      checkOutput($sformatf("v%0d_ready", i), 32'(a_if.s_ready), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d_we", i),    32'(a_if.vram_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        checkOutput($sformatf("v%0d_addr", i), 32'(a_if.vram_waddr), 32'(vecs[i].exp_addr));
        checkOutput($sformatf("v%0d_data", i), 32'(a_if.vram_wdata), 32'(vecs[i].exp_data));
      end
      checkOutput($sformatf("v%0d_done", i), 32'(a_done), 32'(vecs[i].exp_done));
      checkOutput($sformatf("v%0d_err", i),  32'(a_err),  32'(vecs[i].exp_err));
      checkOutput($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vecs[i].exp_busy));
    end
    idleCycles(2);

    $display("[TB] stall mid-frame");
    s0  = wa_q.size();
    dn0 = a_done_cnt;
    er0 = a_err_cnt;
    applyStimulus(12, 0, 1'b1, 5, 8);
    idleCycles(4);
    checkOutput("stall_nwr", 32'(wa_q.size() - s0), 32'd12);
    for (int i = 0; i < 12 && s0 + i < wa_q.size(); i++) begin
      checkOutput($sformatf("stall_addr%0d", i), 32'(wa_q[s0+i]), 32'(100 + i));
      checkOutput($sformatf("stall_data%0d", i), 32'(wd_q[s0+i]), 32'(i));
    end
    checkOutput("stall_done", 32'(a_done_cnt - dn0), 32'd1);
    checkOutput("stall_err",  32'(a_err_cnt - er0),  32'd0);

    $display("[TB] premature sof");
    s0  = wa_q.size();
    dn0 = a_done_cnt;
    er0 = a_err_cnt;
    applyStimulus(5, 0, 1'b1, NO_STALL, NO_STALL);
    applyStimulus(12, 20, 1'b1, NO_STALL, NO_STALL);
    idleCycles(4);
    checkOutput("psof_nwr", 32'(wa_q.size() - s0), 32'd17);
    for (int i = 0; i < 17 && s0 + i < wa_q.size(); i++) begin
      checkOutput($sformatf("psof_addr%0d", i), 32'(wa_q[s0+i]), (i < 5) ? 32'(100 + i) : 32'(95 + i));
      checkOutput($sformatf("psof_data%0d", i), 32'(wd_q[s0+i]), (i < 5) ? 32'(i) : 32'(15 + i));
      checkOutput($sformatf("psof_errflag%0d", i),  32'(werr_q[s0+i]),  32'(i == 5));
      checkOutput($sformatf("psof_doneflag%0d", i), 32'(wdone_q[s0+i]), 32'(i == 16));
    end
    checkOutput("psof_err_cnt",  32'(a_err_cnt - er0),  32'd1);
    checkOutput("psof_done_cnt", 32'(a_done_cnt - dn0), 32'd1);

    $display("[TB] reset mid-frame");
    s0 = wa_q.size();
    applyStimulus(7, 0, 1'b1, NO_STALL, NO_STALL);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("mrst_we",   32'(a_if.vram_we), 32'd0);
    checkOutput("mrst_busy", 32'(a_busy),       32'd0);
    rst = 1'b0;
    idleCycles(2);
    checkOutput("mrst_nwr", 32'(wa_q.size() - s0), 32'd7);
    for (int i = 0; i < 7 && s0 + i < wa_q.size(); i++)
      checkOutput($sformatf("mrst_addr%0d", i), 32'(wa_q[s0+i]), 32'(100 + i));
    s0  = wa_q.size();
    dn0 = a_done_cnt;
    applyStimulus(12, 40, 1'b1, NO_STALL, NO_STALL);
    idleCycles(4);
    checkOutput("post_nwr", 32'(wa_q.size() - s0), 32'd12);
    for (int i = 0; i < 12 && s0 + i < wa_q.size(); i++) begin
      checkOutput($sformatf("post_addr%0d", i), 32'(wa_q[s0+i]), 32'(100 + i));
      checkOutput($sformatf("post_data%0d", i), 32'(wd_q[s0+i]), 32'(40 + i));
    end
    checkOutput("post_done", 32'(a_done_cnt - dn0), 32'd1);

    $display("[TB] full default frame");
    sent = 0;
    cyc  = 0;
    while (sent < 46000 && cyc < 46100) begin
      @(negedge clk);
      b_if.s_valid = 1'b1;
      b_if.s_sof   = (sent == 0);
      b_if.s_data  = 8'(sent);
      #1;
      if (b_if.s_ready === 1'b1) sent++;
      cyc++;
    end
    @(negedge clk);
    b_if.s_valid = 1'b0;
    b_if.s_sof   = 1'b0;
    idleCycles(5);
    checkOutput("full_accepted", 32'(sent),         32'd46000);
    checkOutput("full_nwr",      32'(b_wr_cnt),     32'd46000);
    checkOutput("full_first",    32'(b_first_addr), 32'd0);
    checkOutput("full_last",     32'(b_last_addr),  32'd45999);
    checkOutput("full_max",      32'(b_max_addr),   32'd45999);
    checkOutput("full_done",     32'(b_done_cnt),   32'd1);
    checkOutput("full_busy",     32'(b_busy),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
